// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter fed by a small transmit FIFO. A producer pushes words
//   with a valid/ready handshake. Frames go out back-to-back on uart_txd,
//   LSB first, with optional odd/even parity and one or two stop bits.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset (flushes FIFO, aborts frame)
//   uart_tx_valid  producer presents a word on uart_tx_input
//   uart_tx_input  word to transmit (DATA_BITS wide)
//   uart_tx_ready  FIFO can accept a word this cycle (decoded from fifo_count)
//   uart_txd       registered serial output, idle high
//   uart_tx_busy   registered, high while a frame is on the line
//   fifo_count     registered number of words held in the FIFO
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              uart_tx_valid,
   input  logic [DATA_BITS-1:0]              uart_tx_input,
   output logic                              uart_tx_ready,
   output logic                              uart_txd,
   output logic                              uart_tx_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = $clog2(FIFO_DEPTH + 1);

   localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic [NW-1:0] FULL      = NW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // ---------------- FIFO ----------------
   logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
   logic [NW-1:0]        count_reg;
   logic                 push, pop;
   logic [DATA_BITS-1:0] head;
   logic                 head_par;

   // Ready comes from the registered count only, so a pop in the same cycle
   // never lets a word slip into a full FIFO.
   assign uart_tx_ready = (count_reg != FULL);
   assign push          = uart_tx_valid && uart_tx_ready;
   assign head          = fifo_mem[rd_ptr_reg];
   assign head_par      = (PARITY == 1) ? ~^head : ^head;
   assign fifo_count    = count_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= uart_tx_input;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // ---------------- transmit FSM ----------------
   state_t               state_reg, state_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic                 par_reg, par_next;
   logic [CW-1:0]        cyc_reg, cyc_next;
   logic [BW-1:0]        bit_reg, bit_next;
   logic                 txd_reg, txd_next;
   logic                 busy_reg, busy_next;
   logic                 load;
   logic                 bit_end;

   assign bit_end = (cyc_reg == CYC_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         shift_reg <= '0;
         par_reg   <= 1'b0;
         cyc_reg   <= '0;
         bit_reg   <= '0;
         txd_reg   <= 1'b1;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         par_reg   <= par_next;
         cyc_reg   <= cyc_next;
         bit_reg   <= bit_next;
         txd_reg   <= txd_next;
         busy_reg  <= busy_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      par_next   = par_reg;
      cyc_next   = cyc_reg + 1'b1;
      bit_next   = bit_reg;
      load       = 1'b0;
      pop        = 1'b0;
      txd_next   = 1'b1;
      busy_next  = 1'b0;

      case (state_reg)
         S_IDLE: begin
            cyc_next = cyc_reg;
            load     = (count_reg != '0);
         end
         S_START: begin
            if (bit_end) begin
               cyc_next   = '0;
               state_next = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cyc_next   = '0;
               shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
               if (bit_reg == DATA_LAST) begin
                  bit_next   = '0;
                  state_next = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_next = bit_reg + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               cyc_next   = '0;
               bit_next   = '0;
               state_next = S_STOP;
            end
         end
         S_STOP: begin
            // bit_reg counts stop bits so the cycle counter never has to
            // span more than one bit time.
            if (bit_end) begin
               cyc_next = '0;
               if (bit_reg == STOP_LAST) begin
                  bit_next   = '0;
                  state_next = S_IDLE;
                  load       = (count_reg != '0);
               end else begin
                  bit_next = bit_reg + 1'b1;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase

      // Pop the head straight into START, whether leaving IDLE or chaining
      // from the last stop cycle (zero idle gap between frames).
      if (load) begin
         pop        = 1'b1;
         shift_next = head;
         par_next   = head_par;
         cyc_next   = '0;
         bit_next   = '0;
         state_next = S_START;
      end

      // Outputs are registered: decode the level for the state being entered.
      case (state_next)
         S_START:  txd_next = 1'b0;
         S_DATA:   txd_next = shift_next[0];
         S_PARITY: txd_next = par_next;
         default:  txd_next = 1'b1;
      endcase
      busy_next = (state_next != S_IDLE);
   end

   assign uart_txd     = txd_reg;
   assign uart_tx_busy = busy_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. Three instances share one producer:
//   dut0: no parity, 1 stop bit; dut1: even parity, 1 stop; dut2: odd parity, 2 stop.
// Accepted words go into a per-instance expected queue; a per-instance monitor
// decodes frames on uart_txd and compares every sample against the frame
// expected for the word at the head of that queue.
module tb_uart_tx_fifo;
   localparam int CPB = 20;

   logic       clk;
   logic       reset;
   logic       valid;
   logic [7:0] data;
   logic       ready [3];
   logic       txd   [3];
   logic       busy  [3];
   logic [2:0] count [3];
   int         pending [3];

   int checks;
   int failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dut
         localparam int P     = (gi == 0) ? 0 : ((gi == 1) ? 2 : 1);
         localparam int S     = (gi == 2) ? 2 : 1;
         localparam int NBITS = 1 + 8 + ((P != 0) ? 1 : 0) + S;

         uart_tx_fifo #(
            .CLKS_PER_BIT(CPB),
            .DATA_BITS(8),
            .PARITY(P),
            .STOP_BITS(S),
            .FIFO_DEPTH(4)
         ) u_dut (
            .clk(clk),
            .reset(reset),
            .uart_tx_valid(valid),
            .uart_tx_input(data),
            .uart_tx_ready(ready[gi]),
            .uart_txd(txd[gi]),
            .uart_tx_busy(busy[gi]),
            .fifo_count(count[gi])
         );

         logic [7:0] exp_q [$];
         logic [7:0] mon_word;
         bit         mon_active = 1'b0;
         bit         mon_post   = 1'b0;
         bit         mon_b2b    = 1'b0;
         int         mon_idx    = 0;
         int         mon_errs   = 0;
         int         mon_first  = -1;

         // Expected line level for frame bit b of word w.
         function automatic logic exp_level(input logic [7:0] w, input int b);
            if (b == 0) return 1'b0;
            if (b <= 8) return w[b-1];
            if (P != 0 && b == 9) return (P == 1) ? ~^w : ^w;
            return 1'b1;
         endfunction

         always @(posedge clk) begin
            if (reset) begin
               exp_q.delete();
            end else if (valid && ready[gi]) begin
               exp_q.push_back(data);
            end
            pending[gi] = exp_q.size();
         end

         always @(negedge clk) begin
            if (reset) begin
               mon_active = 1'b0;
               mon_post   = 1'b0;
               exp_q.delete();
            end else begin
               if (mon_post) begin
                  mon_post = 1'b0;
                  checks++;
                  if (mon_b2b) begin
                     if (txd[gi] !== 1'b0) begin
                        failures++;
                        $display("FAIL dut%0d b2b_start txd=%b required=0 (queued word must start with no gap)", gi, txd[gi]);
                     end
                  end else if (busy[gi] !== 1'b0 || txd[gi] !== 1'b1) begin
                     failures++;
                     $display("FAIL dut%0d frame_end busy=%b txd=%b required busy=0 txd=1", gi, busy[gi], txd[gi]);
                  end
               end
               if (!mon_active && txd[gi] === 1'b0) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     failures++;
                     $display("FAIL dut%0d unexpected_frame txd=0 required=1 (no word pending)", gi);
                  end else begin
                     mon_word   = exp_q.pop_front();
                     mon_active = 1'b1;
                     mon_idx    = 0;
                     mon_errs   = 0;
                     mon_first  = -1;
                  end
               end
               if (mon_active) begin
                  if (txd[gi] !== exp_level(mon_word, mon_idx / CPB) || busy[gi] !== 1'b1) begin
                     if (mon_errs == 0) mon_first = mon_idx;
                     mon_errs++;
                  end
                  mon_idx++;
                  if (mon_idx == NBITS * CPB) begin
                     checks++;
                     if (mon_errs != 0) begin
                        failures++;
                        $display("FAIL dut%0d frame word=0x%02h bad_samples=%0d required=0 first_bad_cycle=%0d",
                                 gi, mon_word, mon_errs, mon_first);
                     end else begin
                        $display("dut%0d frame word=0x%02h len=%0d ok", gi, mon_word, NBITS * CPB);
                     end
                     mon_active = 1'b0;
                     mon_post   = 1'b1;
                     mon_b2b    = (exp_q.size() != 0);
                  end
               end
            end
            pending[gi] = exp_q.size();
         end
      end
   endgenerate

   task automatic check(input string name, input int dut, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s dut%0d actual=%0d required=%0d", name, dut, act, exp);
      end
   endtask

   task automatic check_state(input string name, input logic e_txd, input logic e_busy,
                              input int e_count, input logic e_ready);
      for (int i = 0; i < 3; i++) begin
         check({name, "_txd"},   i, int'(txd[i]),   int'(e_txd));
         check({name, "_busy"},  i, int'(busy[i]),  int'(e_busy));
         check({name, "_count"}, i, int'(count[i]), e_count);
         check({name, "_ready"}, i, int'(ready[i]), int'(e_ready));
      end
   endtask

   task automatic push_word(input logic [7:0] w);
      @(negedge clk);
      valid = 1'b1;
      data  = w;
      @(negedge clk);
      valid = 1'b0;
      $display("push word=0x%02h", w);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      valid    = 1'b0;
      data     = 8'h00;
      #1;
      check_state("reset", 1'b1, 1'b0, 0, 1'b1);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);

      // Single word, no gap: pop one edge after the push, line low from then.
      @(negedge clk);
      valid = 1'b1;
      data  = 8'h34;
      @(negedge clk);
      valid = 1'b0;
      $display("push word=0x34");
      check_state("t1_pushed", 1'b1, 1'b0, 1, 1'b1);
      @(negedge clk);
      check_state("t1_popped", 1'b0, 1'b1, 0, 1'b1);
      repeat (260) @(negedge clk);

      // Parity (even -> 0, odd -> 1 for 0x55) and two-stop-bit frame.
      push_word(8'h55);
      repeat (260) @(negedge clk);
      push_word(8'hA5);
      repeat (260) @(negedge clk);
      check_state("idle", 1'b1, 1'b0, 0, 1'b1);

      // Burst with valid held; the sixth word meets a full FIFO, then keep
      // valid high with data changing every cycle while the FIFO stays full.
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         valid = 1'b1;
         data  = 8'(k);
         for (int i = 0; i < 3; i++) check("burst_ready", i, int'(ready[i]), (k < 6) ? 1 : 0);
      end
      for (int i = 0; i < 3; i++) check("burst_count", i, int'(count[i]), 4);
      for (int k = 7; k < 607; k++) begin
         @(negedge clk);
         data = 8'(k);
      end
      @(negedge clk);
      valid = 1'b0;
      repeat (1500) @(negedge clk);
      for (int i = 0; i < 3; i++) check("drain_pending", i, pending[i], 0);
      check_state("drained", 1'b1, 1'b0, 0, 1'b1);

      // Reset about 100 cycles into a frame with two words still queued.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         valid = 1'b1;
         data  = 8'h61 + 8'(k);
      end
      @(negedge clk);
      valid = 1'b0;
      for (int i = 0; i < 3; i++) check("t5_queued", i, int'(count[i]), 2);
      repeat (98) @(negedge clk);
      #3 reset = 1'b1;
      #1;
      check_state("t5_reset", 1'b1, 1'b0, 0, 1'b1);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      repeat (400) @(negedge clk);
      check_state("t5_after", 1'b1, 1'b0, 0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
